// File: rtl/eval_engine.sv
// eval_engine: evaluates a tagged expression word against word memory.
//   NUMBER -> stored constant, NIL -> 0, CONS -> sum of a NIL-terminated list of NUMBERs.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, exp           request evaluation of exp (sampled only in idle)
//   mem_req, mem_addr    one-cycle read request and its address
//   mem_ready, mem_data  one-cycle read response
//   val                  result, held until the next successful completion
//   busy, done           evaluation in progress / one-cycle completion pulse
//   err, err_code        sticky failure flag and reason (1 exp tag, 2 car, 3 cdr, 4 cell limit)
module eval_engine #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MAX_CELLS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] exp,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam int unsigned CNT_W = $clog2(MAX_CELLS + 1);

    localparam logic [TAG_W-1:0] TAG_NUMBER = TAG_W'(0);
    localparam logic [TAG_W-1:0] TAG_NIL    = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_CONS   = TAG_W'(2);

    typedef enum logic [2:0] {
        StIdle, StWaitConst, StWaitCar, StWaitNum, StWaitCdr, StFinish, StFail
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   val_q, val_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   cell_q, cell_d;
    logic                nil_q, nil_d;
    logic                err_q, err_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [TAG_W-1:0]    exp_tag, data_tag, cdr_tag;
    logic [ADDR_W-1:0]   exp_idx, data_idx;
    logic                cdr_valid;

    // The mark bit belongs to the garbage collector and is never looked at here.
    logic unused_mark;
    assign unused_mark = exp[WORD_W-1] ^ mem_data[WORD_W-1];

    assign exp_tag  = exp[WORD_W-2 -: TAG_W];
    assign exp_idx  = exp[ADDR_W-1:0];
    assign data_tag = mem_data[WORD_W-2 -: TAG_W];
    assign data_idx = mem_data[ADDR_W-1:0];

    // A bare NIL expression is handled as an empty list tail: it passes through the cdr
    // stage once with a synthetic NIL word, giving the same two-cycle completion as a list end.
    assign cdr_valid = nil_q | mem_ready;
    assign cdr_tag   = nil_q ? TAG_NIL : data_tag;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        val_d      = val_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        cell_d     = cell_q;
        nil_d      = nil_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d      = 1'b0;
                    err_code_d = 3'd0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    nil_d      = 1'b0;
                    cell_d     = exp_idx;
                    case (exp_tag)
                        TAG_NUMBER: begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = exp_idx;
                            state_d    = StWaitConst;
                        end
                        TAG_NIL: begin
                            nil_d   = 1'b1;
                            state_d = StWaitCdr;
                        end
                        TAG_CONS: begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = exp_idx;
                            cnt_d      = CNT_W'(1);
                            state_d    = StWaitCar;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = 3'd1;
                            state_d    = StFail;
                        end
                    endcase
                end
            end
            StWaitConst: begin
                if (mem_ready) begin
                    val_d   = mem_data;
                    state_d = StFinish;
                end
            end
            StWaitCar: begin
                if (mem_ready) begin
                    if (data_tag == TAG_NUMBER) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = data_idx;
                        state_d    = StWaitNum;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd2;
                        state_d    = StFail;
                    end
                end
            end
            StWaitNum: begin
                if (mem_ready) begin
                    acc_d      = acc_q + mem_data;
                    mem_req_d  = 1'b1;
                    mem_addr_d = cell_q + ADDR_W'(1);
                    state_d    = StWaitCdr;
                end
            end
            StWaitCdr: begin
                if (cdr_valid) begin
                    nil_d = 1'b0;
                    case (cdr_tag)
                        TAG_NIL: begin
                            val_d   = acc_q;
                            state_d = StFinish;
                        end
                        TAG_CONS: begin
                            if (cnt_q == CNT_W'(MAX_CELLS)) begin
                                err_d      = 1'b1;
                                err_code_d = 3'd4;
                                state_d    = StFail;
                            end else begin
                                cnt_d      = cnt_q + CNT_W'(1);
                                cell_d     = data_idx;
                                mem_req_d  = 1'b1;
                                mem_addr_d = data_idx;
                                state_d    = StWaitCar;
                            end
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = 3'd3;
                            state_d    = StFail;
                        end
                    endcase
                end
            end
            StFinish: state_d = StIdle;
            StFail:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            val_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            cell_q     <= '0;
            nil_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            val_q      <= val_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cell_q     <= cell_d;
            nil_q      <= nil_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign val      = val_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign done     = (state_q == StFinish);
    assign busy     = (state_q == StWaitConst) || (state_q == StWaitCar) ||
                      (state_q == StWaitNum) || (state_q == StWaitCdr);

endmodule

// File: tb/tb_eval_engine.sv
module tb_eval_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] exp_w;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] val;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    eval_engine #(
        .WORD_W   (16),
        .TAG_W    (3),
        .ADDR_W   (12),
        .MAX_CELLS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .exp      (exp_w),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready),
        .mem_data (mem_data),
        .val      (val),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    bit auto_resp = 1'b1;
    int req_cnt = 0;
    int done_cnt = 0;
    int b2b = 0;
    bit prev_req = 1'b0;
    logic [11:0] last_addr = '0;

    always @(posedge clk) cyc++;

    // Bus monitor: request/done counts and back-to-back request detection.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cnt++;
            last_addr = mem_addr;
            if (prev_req) b2b++;
        end
        prev_req = mem_req;
        if (done) done_cnt++;
    end

    // Memory model: ready pulse 'lat' cycles after the request cycle.
    initial begin
        logic [11:0] a;
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_req && auto_resp) begin
                a = mem_addr;
                repeat (lat) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_data  = mem[a];
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Issue one START; fin = cycle of DONE/ERR relative to START cycle (-1 on timeout).
    task automatic run(input logic [15:0] e, output int fin, output int bf, output int bl);
        int t0;
        req_cnt  = 0;
        done_cnt = 0;
        b2b      = 0;
        @(posedge clk);
        #1;
        exp_w = e;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        fin = -1;
        bf  = -1;
        bl  = -1;
        for (int i = 0; i < 300 && fin < 0; i++) begin
            @(negedge clk);
            if (busy) begin
                if (bf < 0) bf = cyc - t0;
                bl = cyc - t0;
            end
            if (done || err) fin = cyc - t0;
        end
        repeat (3) @(negedge clk);
    endtask

    int fin, bf, bl;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[1]    = 16'h00AB;
        // list (1 2 3) at cells 16,18,20; car at 16 carries a set mark bit
        mem[16]   = 16'h8064; mem[17] = 16'h2012;
        mem[18]   = 16'h0065; mem[19] = 16'h2014;
        mem[20]   = 16'h0066; mem[21] = 16'h1000;
        mem[100]  = 16'd1; mem[101] = 16'd2; mem[102] = 16'd3;
        // list (FFFF 2)
        mem[30]   = 16'h0068; mem[31] = 16'h2020;
        mem[32]   = 16'h0069; mem[33] = 16'h1000;
        mem[104]  = 16'hFFFF; mem[105] = 16'd2;
        // self-referencing cell
        mem[40]   = 16'h0064; mem[41] = 16'h2028;
        // bad car tag, bad cdr tag
        mem[50]   = 16'h1000;
        mem[60]   = 16'h0064; mem[61] = 16'h3000;
        // cell at the top of memory: cdr address wraps to 0
        mem[4095] = 16'h0065; mem[0] = 16'h1000;

        rst_n = 1'b0;
        start = 1'b0;
        exp_w = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_val", val, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_code", err_code, 0);
        rst_n = 1'b1;

        lat = 1;
        run(16'h0001, fin, bf, bl);
        check_eq("num_l1_done_cycle", fin, 3);
        check_eq("num_l1_addr", last_addr, 1);
        check_eq("num_l1_val", val, 16'h00AB);
        check_eq("num_l1_err", err, 0);
        check_eq("num_l1_reqs", req_cnt, 1);
        check_eq("num_l1_dones", done_cnt, 1);

        lat = 5;
        run(16'h0001, fin, bf, bl);
        check_eq("num_l5_done_cycle", fin, 7);
        check_eq("num_l5_reqs", req_cnt, 1);
        check_eq("num_l5_busy_first", bf, 1);
        check_eq("num_l5_busy_last", bl, 6);

        lat = 2;
        run(16'h2010, fin, bf, bl);
        check_eq("list123_val", val, 6);
        check_eq("list123_reqs", req_cnt, 9);
        check_eq("list123_dones", done_cnt, 1);
        check_eq("list123_done_cycle", fin, 28);
        check_eq("list123_b2b", b2b, 0);

        lat = 1;
        run(16'h201E, fin, bf, bl);
        check_eq("wrap_val", val, 16'h0001);
        check_eq("wrap_err", err, 0);

        lat = 3;
        run(16'h2028, fin, bf, bl);
        check_eq("cycle_err", err, 1);
        check_eq("cycle_code", err_code, 4);
        check_eq("cycle_reqs", req_cnt, 12);
        check_eq("cycle_val", val, 16'h0001);
        check_eq("cycle_dones", done_cnt, 0);

        lat = 1;
        run(16'h2032, fin, bf, bl);
        check_eq("badcar_code", err_code, 2);
        run(16'h203C, fin, bf, bl);
        check_eq("badcdr_code", err_code, 3);
        check_eq("badcdr_val", val, 16'h0001);

        run(16'h7005, fin, bf, bl);
        check_eq("badexp_err", err, 1);
        check_eq("badexp_code", err_code, 1);
        check_eq("badexp_reqs", req_cnt, 0);
        check_eq("badexp_busy", bf, 32'hFFFF_FFFF);

        run(16'h1000, fin, bf, bl);
        check_eq("nil_done_cycle", fin, 2);
        check_eq("nil_val", val, 0);
        check_eq("nil_err_cleared", err, 0);
        check_eq("nil_reqs", req_cnt, 0);

        run(16'h2FFF, fin, bf, bl);
        check_eq("topcell_val", val, 16'h0002);
        check_eq("topcell_err", err, 0);

        // Reset while waiting for a car word, then a stale ready arrives.
        auto_resp = 1'b0;
        @(posedge clk);
        #1;
        exp_w = 16'h2010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("abort_req_issued", mem_req, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_val", val, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        req_cnt  = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        mem_data  = 16'h0064;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stale_reqs", req_cnt, 0);
        check_eq("stale_busy", busy, 0);
        check_eq("stale_dones", done_cnt, 0);
        check_eq("stale_err", err, 0);
        check_eq("stale_val", val, 0);
        auto_resp = 1'b1;
        run(16'h0001, fin, bf, bl);
        check_eq("after_reset_val", val, 16'h00AB);
        check_eq("after_reset_done_cycle", fin, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
